// File: rtl/io_bus_bridge.sv
// Byte-wide cpu bus bridge: RAM/IO decode, UART TX FIFO with backpressure, RX pop,
// cycle counter with coherent snapshot, program stop. Optional: IO_BUS_BRIDGE_DROP_CNT_EN.
module io_bus_bridge #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int FULL_MARGIN   = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        ram_we,
   input  logic [7:0]  ram_dout,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_stop,
   output logic [7:0]  dbg_drop_cnt
);
   localparam int PW = TX_DEPTH_LOG2;
   localparam int CW = TX_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(2**TX_DEPTH_LOG2);
   localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

   logic          io_s;
   logic [2:0]    sel_s;
   logic          rd_acc_s;
   logic          wr_acc_s;
   logic          stop_set_s;
   logic          push_req_s;
   logic          push_ok_s;
   logic          pop_s;
   logic [CW-1:0] count_next_s;
   logic [CW-1:0] free_next_s;
   logic [7:0]    io_rd_data_s;

   logic [7:0]    fifo_mem_r [2**TX_DEPTH_LOG2];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   cnt_r;
   logic [31:0]   snap_r;
   logic          stop_req_r;
   logic          program_stop_r;
   logic          io_buffer_full_r;
   logic          io_sel_r;
   logic [7:0]    io_rdata_r;

   logic          unused_addr_s;
   assign unused_addr_s = ^{mem_a[31:18], mem_a[15:3]};

   // Access decode, FIFO push/pop arbitration and IO read mux.
   always_comb begin
      io_s       = (mem_a[17:16] == 2'b11);
      sel_s      = mem_a[2:0];
      rd_acc_s   = rdy_in & ~mem_wr & ~rst_in;
      wr_acc_s   = rdy_in &  mem_wr & ~rst_in;
      stop_set_s = wr_acc_s & io_s & (sel_s == 3'd4);
      push_req_s = stop_set_s | (wr_acc_s & io_s & (sel_s == 3'd0) & (mem_dout != 8'h00));
      pop_s      = (count_r != {CW{1'b0}}) & tx_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push_ok_s  = push_req_s & ((count_r != DEPTH_C) | pop_s);
      case ({push_ok_s, pop_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
      free_next_s = DEPTH_C - count_next_s;
      case (sel_s)
         3'd0:    io_rd_data_s = rx_valid ? rx_data : 8'h00;
         3'd4:    io_rd_data_s = cnt_r[7:0];
         3'd5:    io_rd_data_s = snap_r[15:8];
         3'd6:    io_rd_data_s = snap_r[23:16];
         3'd7:    io_rd_data_s = snap_r[31:24];
         default: io_rd_data_s = 8'h00;
      endcase
   end

   assign rx_pop         = rd_acc_s & io_s & (sel_s == 3'd0) & rx_valid;
   assign ram_we         = wr_acc_s & ~io_s;
   assign tx_valid       = (count_r != {CW{1'b0}});
   assign tx_data        = fifo_mem_r[rd_ptr_r];
   assign mem_din        = io_sel_r ? io_rdata_r : ram_dout;
   assign io_buffer_full = io_buffer_full_r;
   assign program_stop   = program_stop_r;

   // FIFO storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk_in) begin
      if (push_ok_s) begin
         fifo_mem_r[wr_ptr_r] <= stop_set_s ? 8'h00 : mem_dout;
      end
   end

   // Control state: FIFO pointers, counter, snapshot, read return, stop tracking.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_r         <= {PW{1'b0}};
         rd_ptr_r         <= {PW{1'b0}};
         count_r          <= {CW{1'b0}};
         cnt_r            <= 32'h0000_0000;
         snap_r           <= 32'h0000_0000;
         stop_req_r       <= 1'b0;
         program_stop_r   <= 1'b0;
         io_buffer_full_r <= 1'b0;
         io_sel_r         <= 1'b1;
         io_rdata_r       <= 8'h00;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r          <= count_next_s;
         io_buffer_full_r <= (free_next_s <= MARGIN_C);
         if (rdy_in) begin
            cnt_r <= cnt_r + 32'd1;
         end
         if (rd_acc_s) begin
            io_sel_r   <= io_s;
            io_rdata_r <= io_rd_data_s;
            if (io_s && (sel_s == 3'd4)) begin
               snap_r <= cnt_r;
            end
         end
         if (stop_set_s) begin
            stop_req_r <= 1'b1;
         end
         // Stop is reported only once the terminating 0x00 has left the FIFO.
         if (stop_req_r && (count_r == {CW{1'b0}})) begin
            program_stop_r <= 1'b1;
         end
      end
   end

`ifdef IO_BUS_BRIDGE_DROP_CNT_EN
   logic [7:0] drop_cnt_r;

   // Saturating count of IO pushes lost to a full FIFO.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_cnt_r <= 8'h00;
      end else if (push_req_s && !push_ok_s && (drop_cnt_r != 8'hFF)) begin
         drop_cnt_r <= drop_cnt_r + 8'h01;
      end
   end

   assign dbg_drop_cnt = drop_cnt_r;
`else
   assign dbg_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge: directed scenarios plus randomized traffic
// checked against a queue/array reference model of the bus, FIFO and counter.
module tb_io_bus_bridge;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b0;
   logic [31:0] mem_a = 32'h0;
   logic [7:0]  mem_dout = 8'h00;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        ram_we;
   logic [7:0]  ram_dout = 8'h00;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        program_stop;
   logic [7:0]  dbg_drop_cnt;

   always #5 clk_in = ~clk_in;

   io_bus_bridge dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full), .ram_we(ram_we), .ram_dout(ram_dout),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_stop(program_stop), .dbg_drop_cnt(dbg_drop_cnt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         due;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] tx_q[$];

   // reference model state
   logic [7:0]  model_ram [256];
   logic [7:0]  ram_arr [256];
   int          occ;
   logic [31:0] m_cnt;
   logic [31:0] m_snap;
   bit          m_stop;
   bit          m_pstop;
   int          m_drops;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   always @(posedge clk_in) cyc <= cyc + 1;

   // environment RAM with one-cycle read latency
   always @(posedge clk_in) begin
      if (ram_we) ram_arr[mem_a[7:0]] <= mem_dout;
      ram_dout <= ram_arr[mem_a[7:0]];
   end

   // monitor: TX handshakes and read returns against the scoreboard queues
   always @(negedge clk_in) begin : mon
      rd_exp_t e;
      if (!rst_in && tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_extra got=%0h exp=none", tx_data);
         end else begin
            chk("tx_data", tx_data, tx_q.pop_front());
         end
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         e = rd_q.pop_front();
         chk("mem_din", mem_din, e.data);
      end
   end

   function automatic logic [7:0] exp_drop();
`ifdef IO_BUS_BRIDGE_DROP_CNT_EN
      return 8'(m_drops);
`else
      return 8'h00;
`endif
   endfunction

   // One bus cycle: drive, predict, clock, check registered outputs.
   task automatic cycle(input bit rdy, input bit wr, input logic [17:0] a, input logic [7:0] d);
      bit          io, pop, push, ok, stop_set;
      int          s, occ_before;
      logic [7:0]  rdv;
      logic [31:0] snap_next;
      rdy_in   = rdy;
      mem_wr   = wr;
      mem_a    = {14'($urandom), a};
      mem_dout = d;
      io       = (a[17:16] == 2'b11);
      s        = int'(a[2:0]);
      pop      = (occ > 0) && tx_ready;
      stop_set = rdy && wr && io && (s == 4);
      push     = stop_set || (rdy && wr && io && s == 0 && d != 8'h00);
      ok       = push && (occ < 16 || pop);
      snap_next = m_snap;
      #2;
      chk("rx_pop", rx_pop, rdy && !wr && io && s == 0 && rx_valid);
      chk("ram_we", ram_we, rdy && wr && !io);
      if (rdy && !wr) begin
         if (!io)                 rdv = model_ram[a[7:0]];
         else if (s == 0)         rdv = rx_valid ? rx_data : 8'h00;
         else if (s == 4)         rdv = m_cnt[7:0];
         else if (s >= 5)         rdv = m_snap[8*(s-4) +: 8];
         else                     rdv = 8'h00;
         rd_q.push_back('{due: cyc + 1, data: rdv});
         if (io && s == 4) snap_next = m_cnt;
      end
      if (rdy && wr && !io) model_ram[a[7:0]] = d;
      @(posedge clk_in);
      occ_before = occ;
      if (ok) tx_q.push_back(stop_set ? 8'h00 : d);
      occ = occ + (ok ? 1 : 0) - (pop ? 1 : 0);
      if (push && !ok && m_drops < 255) m_drops++;
      if (m_stop && occ_before == 0) m_pstop = 1'b1;
      if (stop_set) m_stop = 1'b1;
      if (rdy) m_cnt = m_cnt + 32'd1;
      m_snap = snap_next;
      #1;
      chk("io_buffer_full", io_buffer_full, occ >= 14);
      chk("tx_valid", tx_valid, occ > 0);
      chk("program_stop", program_stop, m_pstop);
      chk("dbg_drop_cnt", dbg_drop_cnt, exp_drop());
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 18'h30002, 8'h00);
   endtask

   task automatic do_reset();
      rst_in   = 1'b1;
      rdy_in   = 1'b0;
      mem_wr   = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      occ = 0; m_cnt = 32'h0; m_snap = 32'h0;
      m_stop = 1'b0; m_pstop = 1'b0; m_drops = 0;
      tx_q.delete();
      rd_q.delete();
      chk("rst_mem_din", mem_din, 8'h00);
      chk("rst_full", io_buffer_full, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_rx_pop", rx_pop, 1'b0);
      chk("rst_program_stop", program_stop, 1'b0);
      chk("rst_drop_cnt", dbg_drop_cnt, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      logic [17:0] ra;
      for (int i = 0; i < 256; i++) begin
         model_ram[i] = 8'($urandom);
         ram_arr[i]   = model_ram[i];
      end
      model_ram[0] = 8'hA5;
      ram_arr[0]   = 8'hA5;
      do_reset();

      // "Hi" then a ignored zero byte
      tx_ready = 1'b1;
      cycle(1'b1, 1'b1, 18'h30000, 8'h48);
      cycle(1'b1, 1'b1, 18'h30000, 8'h69);
      cycle(1'b1, 1'b1, 18'h30000, 8'h00);
      nop(4);
      chk("hi_drained", tx_q.size(), 0);

      // fill to backpressure, then overflow by one
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, 18'h30000, 8'(i + 1));
      chk("fifo_occ_16", occ, 16);
      tx_ready = 1'b1;
      nop(20);

      // coherent counter dword read
      guard = 0;
      while (m_cnt != 32'h1FF && guard < 1000) begin
         nop(1);
         guard++;
      end
      chk("cnt_reach_1ff", m_cnt, 32'h1FF);
      cycle(1'b1, 1'b0, 18'h30004, 8'h00);
      cycle(1'b1, 1'b0, 18'h30005, 8'h00);
      cycle(1'b1, 1'b0, 18'h30006, 8'h00);
      cycle(1'b1, 1'b0, 18'h30007, 8'h00);
      chk("snap_value", m_snap, 32'h1FF);

      // RX pop with and without data
      rx_valid = 1'b1; rx_data = 8'h37;
      cycle(1'b1, 1'b0, 18'h30000, 8'h00);
      rx_valid = 1'b0;
      cycle(1'b1, 1'b0, 18'h30000, 8'h00);

      // RAM read/write, then the same with rdy low
      cycle(1'b1, 1'b0, 18'h00100, 8'h00);
      cycle(1'b1, 1'b1, 18'h00100, 8'h3C);
      cycle(1'b1, 1'b0, 18'h00100, 8'h00);
      cycle(1'b0, 1'b1, 18'h00100, 8'h77);
      cycle(1'b0, 1'b0, 18'h00100, 8'h00);
      cycle(1'b1, 1'b0, 18'h00100, 8'h00);
      cycle(1'b1, 1'b0, 18'h30004, 8'h00);

      // program stop after draining
      tx_ready = 1'b0;
      cycle(1'b1, 1'b1, 18'h30000, 8'h41);
      cycle(1'b1, 1'b1, 18'h30000, 8'h42);
      cycle(1'b1, 1'b1, 18'h30000, 8'h43);
      cycle(1'b1, 1'b1, 18'h30004, 8'h55);
      nop(2);
      tx_ready = 1'b1;
      nop(8);
      chk("stop_held", program_stop, 1'b1);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         tx_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         if (i >= 450) tx_ready = 1'b1;
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            ra = 18'h30000 | 18'($urandom_range(0, 7));
         end else begin
            ra[17:16] = 2'($urandom_range(0, 2));
            ra[15:0]  = 16'($urandom);
         end
         cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), ra,
               ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end

      // reset with bytes still queued
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 18'h30000, 8'hA0 + 8'(i));
      do_reset();
      tx_ready = 1'b1;
      nop(4);

      chk("tx_q_empty", tx_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
